// File: rtl/inbuf_cal_pkg.sv
// Shared types and helpers for the INBUF offset calibrator: FSM states and
// the sweep-index to OSC code mapping.
package inbuf_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        EVAL,
        DONE
    } cal_state_t;

    localparam logic [3:0] OSC_ZERO = 4'b1000;

    // Index 0..15 walks the offset from -35 through -0, +0 up to +35 in steps of 5
    function automatic logic [3:0] idx2code(input logic [3:0] i);
        if (i[3]) begin
            return {1'b1, i[2:0]};
        end else begin
            return {1'b0, 3'd7 - i[2:0]};
        end
    endfunction

endpackage

// File: rtl/inbuf_cal_sync.sv
// Two-flop synchroniser bringing the asynchronous INBUF output into the clk domain.
module inbuf_cal_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/inbuf_offset_cal.sv
// Sweeps the 16 INBUF offset codes and picks the first one where the buffer output turns to 1.
// Define INBUF_OFFSET_CAL_TRACE_EN to expose the last evaluated index and ones count.
module inbuf_offset_cal
    import inbuf_cal_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pad_o,
    output logic [3:0] osc,
    output logic       osc_en,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [3:0] cal_code,
    output logic [3:0] trace_idx,
    output logic [8:0] trace_ones
);

    localparam int OW   = $clog2(SAMPLES) + 1;
    localparam int CMAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CW   = $clog2(CMAX) + 1;

    cal_state_t    state_q;
    logic [3:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [OW-1:0] ones_q;
    logic [3:0]    osc_q;
    logic          osc_en_q;
    logic          busy_q;
    logic          done_q;
    logic          found_q;
    logic [3:0]    cal_code_q;
    logic          pad_sync;
    logic          hit;

    inbuf_cal_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_o),
        .q     (pad_sync)
    );

    // Majority vote: at least half of the samples for this code saw a 1
    assign hit = {ones_q, 1'b0} >= (OW + 1)'(SAMPLES);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            ones_q     <= '0;
            osc_q      <= OSC_ZERO;
            osc_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            cal_code_q <= OSC_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        ones_q   <= '0;
                        osc_q    <= idx2code(4'd0);
                        osc_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SAMPLE: begin
                    ones_q <= ones_q + OW'(pad_sync);
                    if (cnt_q == CW'(SAMPLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= EVAL;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                EVAL: begin
                    if (hit || idx_q == 4'd15) begin
                        // A hit on the very first code means the buffer is saturated positive
                        found_q    <= hit && (idx_q != 4'd0);
                        cal_code_q <= osc_q;
                        done_q     <= 1'b1;
                        osc_en_q   <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        osc_q   <= idx2code(idx_q + 4'd1);
                        ones_q  <= '0;
                        state_q <= SETTLE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign osc      = osc_q;
    assign osc_en   = osc_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign found    = found_q;
    assign cal_code = cal_code_q;

`ifdef INBUF_OFFSET_CAL_TRACE_EN
    logic [3:0] trace_idx_q;
    logic [8:0] trace_ones_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trace_idx_q  <= '0;
            trace_ones_q <= '0;
        end else if (state_q == EVAL) begin
            trace_idx_q  <= idx_q;
            trace_ones_q <= 9'(ones_q);
        end
    end

    assign trace_idx  = trace_idx_q;
    assign trace_ones = trace_ones_q;
`else
    assign trace_idx  = '0;
    assign trace_ones = '0;
`endif

endmodule

// File: tb/tb_inbuf_offset_cal.sv
// Self-checking bench for inbuf_offset_cal: an INBUF behavioural model closes the loop and a
// sweep-level reference predicts the result, latency and trace for random buffer offsets.
module tb_inbuf_offset_cal;

    localparam int SETTLE   = 16;
    localparam int NSAMP    = 64;
    localparam int PER_CODE = SETTLE + NSAMP + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       padO;
    logic [3:0] osc;
    logic       oscEn;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] calCode;
    logic [3:0] traceIdx;
    logic [8:0] traceOnes;

    int offsetVal = 0;
    int checks = 0;
    int errors = 0;
    int doneCount = 0;

    inbuf_offset_cal #(
        .SETTLE_CYCLES (SETTLE),
        .SAMPLES       (NSAMP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pad_o      (padO),
        .osc        (osc),
        .osc_en     (oscEn),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .cal_code   (calCode),
        .trace_idx  (traceIdx),
        .trace_ones (traceOnes)
    );

    always #5 clk = ~clk;

    // INBUF model: sign bit selects direction, magnitude counts 5-unit steps
    function automatic int oscOffset(input logic [3:0] c);
        int m;
        m = 5 * int'(c[2:0]);
        return c[3] ? m : -m;
    endfunction

    assign padO = (offsetVal + oscOffset(osc)) > 0;

    always @(posedge clk) begin
        if (rst_n && done) doneCount++;
    end

    // Applied offset at sweep position i, monotonic from -35 to +35
    function automatic int sweepOffset(input int i);
        return (i < 8) ? (5 * i - 35) : (5 * i - 40);
    endfunction

    function automatic logic [3:0] codeAt(input int i);
        int off;
        int mag;
        off = sweepOffset(i);
        mag = (off < 0 ? -off : off) / 5;
        return {(i >= 8) ? 1'b1 : 1'b0, 3'(mag)};
    endfunction

    function automatic void predict(input int offset, output bit expFound,
                                    output logic [3:0] expCode, output int expCodes,
                                    output int expOnes);
        expFound = 1'b0;
        expCode  = codeAt(15);
        expCodes = 16;
        expOnes  = 0;
        for (int i = 0; i < 16; i++) begin
            if (offset + sweepOffset(i) > 0) begin
                expFound = (i != 0);
                expCode  = codeAt(i);
                expCodes = i + 1;
                expOnes  = NSAMP;
                return;
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_osc"}, osc, 4'b1000);
        checkOutput({tag, "_osc_en"}, oscEn, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_found"}, found, 0);
        checkOutput({tag, "_cal_code"}, calCode, 4'b1000);
        checkOutput({tag, "_trace_idx"}, traceIdx, 0);
        checkOutput({tag, "_trace_ones"}, traceOnes, 0);
    endtask

    task automatic applyStimulus(input int offset, input bit pulseBusy, input bit pulseDone);
        bit         expFound;
        logic [3:0] expCode;
        int         expCodes;
        int         expOnes;
        int         cycles;
        int         donesBefore;
        offsetVal = offset;
        predict(offset, expFound, expCode, expCodes, expOnes);
        donesBefore = doneCount;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 16 * PER_CODE + 10) begin
            @(posedge clk);
            #1;
            cycles++;
            start = pulseBusy && (cycles == 40);
            if (!done && (cycles % PER_CODE) == 40) begin
                checkOutput("osc_mid", osc, codeAt(cycles / PER_CODE));
                checkOutput("busy_mid", busy, 1);
                checkOutput("osc_en_mid", oscEn, 1);
            end
        end
        start = 1'b0;
        checkOutput("done_seen", done, 1);
        checkOutput("latency", cycles, expCodes * PER_CODE);
        checkOutput("found", found, expFound);
        checkOutput("cal_code", calCode, expCode);
        checkOutput("osc_done", osc, expCode);
        checkOutput("osc_en_done", oscEn, 0);
        checkOutput("busy_done", busy, 1);
`ifdef INBUF_OFFSET_CAL_TRACE_EN
        checkOutput("trace_idx", traceIdx, expCodes - 1);
        checkOutput("trace_ones", traceOnes, expOnes);
`else
        checkOutput("trace_idx", traceIdx, 0);
        checkOutput("trace_ones", traceOnes, 0);
`endif
        if (pulseDone) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("done_pulse", done, 0);
        checkOutput("busy_after", busy, 0);
        checkOutput("cal_code_hold", calCode, expCode);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("busy_idle", busy, 0);
        checkOutput("done_count", doneCount - donesBefore, 1);
    endtask

    initial begin
        int offset;
        int dones;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(12, 1'b0, 1'b0);
        applyStimulus(-7, 1'b0, 1'b0);
        applyStimulus(40, 1'b0, 1'b1);
        applyStimulus(-40, 1'b1, 1'b0);

        // Abort a sweep in the middle of sampling code 6
        offsetVal = -40;
        dones = doneCount;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6 * PER_CODE + 40) @(posedge clk);
        #1;
        checkOutput("pre_rst_osc", osc, codeAt(6));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkResetValues("mid_rst");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid_rst_no_done", doneCount - dones, 0);
        checkOutput("mid_rst_idle", busy, 0);

        applyStimulus(3, 1'b1, 1'b1);

        for (int n = 0; n < 6; n++) begin
            offset = int'($urandom_range(90, 0)) - 45;
            applyStimulus(offset, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
